// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack CPU constants and program-counter operation encoding
package hack_pkg;

  localparam int          HACK_WIDTH      = 16;
  localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_LOAD  = 2'd2,
    PC_CLEAR = 2'd3
  } pc_op_t;

endpackage

// File: rtl/inc_16.sv
// rtl/inc_16.sv - combinational +1 incrementer with carry-out
module inc_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o
);

  // Carry-out is set exactly when in_i is all-ones, so it doubles as the wrap detect.
  assign {carry_o, out_o} = {1'b0, in_i} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/mux_16.sv
// rtl/mux_16.sv - 16-bit two-way word multiplexer from the Hack gate library
module mux_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/pc_16.sv
// rtl/pc_16.sv - Hack program counter: clear > load > inc > hold, with wrap/jump pulses
module pc_16
  import hack_pkg::*;
#(
  parameter int               WIDTH       = HACK_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET_VECTOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             wrapped,
  output logic             jumped
);

  pc_op_t           op;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrapped_q, wrapped_d;
  logic             jumped_q, jumped_d;
  logic [WIDTH-1:0] inc_val;
  logic             inc_carry;
  logic [WIDTH-1:0] sel_inc, sel_load;

  always_comb begin
    op = PC_HOLD;
    if (clear)     op = PC_CLEAR;
    else if (load) op = PC_LOAD;
    else if (inc)  op = PC_INC;
  end

  inc_16 #(.WIDTH(WIDTH)) u_inc (
    .in_i   (out_q),
    .out_o  (inc_val),
    .carry_o(inc_carry)
  );

  // Chain is ordered lowest priority first so the last stage (clear) dominates.
  mux_16 #(.WIDTH(WIDTH)) u_mux_inc (
    .a_i  (out_q),
    .b_i  (inc_val),
    .sel_i(op == PC_INC),
    .out_o(sel_inc)
  );

  mux_16 #(.WIDTH(WIDTH)) u_mux_load (
    .a_i  (sel_inc),
    .b_i  (in),
    .sel_i(op == PC_LOAD),
    .out_o(sel_load)
  );

  mux_16 #(.WIDTH(WIDTH)) u_mux_clear (
    .a_i  (sel_load),
    .b_i  (RESET_VALUE),
    .sel_i(op == PC_CLEAR),
    .out_o(out_d)
  );

  assign wrapped_d = (op == PC_INC) && inc_carry;
  assign jumped_d  = (op == PC_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= RESET_VALUE;
      wrapped_q <= 1'b0;
      jumped_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      wrapped_q <= wrapped_d;
      jumped_q  <= jumped_d;
    end
  end

  assign out     = out_q;
  assign wrapped = wrapped_q;
  assign jumped  = jumped_q;

endmodule

// File: doc/pc_16.md
Name: pc_16

Overview:
- Hack program counter. Holds the 16-bit address of the next instruction and drives the instruction-ROM address.
- Consumes the 16-bit jump target from the A-register path, which is built on the 16-bit gate library (not_16, and_16, mux_16).
- Per cycle it can hold, increment, load a jump target, or clear to the reset vector.
- Sits between the CPU jump logic and the instruction ROM.

Parameters:
- WIDTH, 16, datapath width in bits. Only 16 is verified.
- RESET_VALUE, 16'h0000, value of out after async reset and after clear.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous reset, active-low
- in  input  WIDTH  jump target, sampled when load=1
- load  input  1  load in on the next edge
- inc  input  1  increment on the next edge
- clear  input  1  synchronous clear to RESET_VALUE (the Hack "reset" pin)
- out  output  WIDTH  current program counter
- wrapped  output  1  one-cycle pulse: the last increment wrapped all-ones to zero
- jumped  output  1  one-cycle pulse: the last update was a load

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n=0: out=RESET_VALUE, wrapped=0, jumped=0 immediately, with no clock required. Outputs are held while rst_n=0.
- Release of rst_n is sampled on the next rising edge; the first update can occur on that edge.
- Per rising edge, priority is clear > load > inc > hold:
  - clear=1: out<=RESET_VALUE, wrapped<=0, jumped<=0.
  - else load=1: out<=in, jumped<=1, wrapped<=0. inc is ignored.
  - else inc=1: out<=out+1 modulo 2^WIDTH. wrapped<=1 only if the old out was all-ones; jumped<=0.
  - else: out holds, wrapped<=0, jumped<=0.
- Latency: one cycle from control inputs to out. No combinational path from any input to any output.
- wrapped and jumped are registered, and each is high for exactly the one cycle following its causing edge. They are never both 1.
- load of the value already in out still pulses jumped.
- clear asserted together with load and inc: clear wins and no flags are set.
- Control inputs are level-sampled. Holding inc for N cycles advances out by N, modulo 2^WIDTH.
- rst_n asserted mid-sequence: an in-progress load or inc is discarded, and out returns to RESET_VALUE asynchronously.
- X on load/inc/clear while rst_n=1 is a bench error. An assertion in the bench flags it.

Decomposition:
- Package hack_pkg holds:
  - constant HACK_WIDTH=16
  - constant PC_RESET_VECTOR=16'h0000
  - enum pc_op_t {PC_HOLD, PC_INC, PC_LOAD, PC_CLEAR}, produced by the priority decode
- Sub-module inc_16: combinational out=in+1 plus a carry-out. The carry-out is used as the wrap detect.
- pc_16 contains:
  - the decode to pc_op_t
  - a mux_16 chain selecting the next value
  - the state register with async reset

Test Plan:
- Reset: rst_n=0 mid-cycle with out=16'h0042 -> out=16'h0000, wrapped=0, jumped=0 before the next edge. Release, hold 3 cycles -> out stays 16'h0000.
- Increment: inc=1 for 5 edges from 16'h0000 -> out steps 1,2,3,4,5. wrapped and jumped stay 0.
- Wrap: load in=16'hFFFE, then inc for 2 edges:
  - out=16'hFFFF, then 16'h0000
  - wrapped=1 only in the cycle out=16'h0000
  - jumped=1 only in the cycle out=16'hFFFE
- Priority: out=16'h0010; apply load=1, in=16'h1234, inc=1 -> out=16'h1234, jumped=1. Next edge clear=1, load=1, inc=1 -> out=16'h0000, both flags 0.
- Hold and reload-same: all controls 0 for 4 edges at 16'h00AA -> unchanged, flags 0. Then load in=16'h00AA -> out=16'h00AA, jumped=1 for one cycle.
- Async reset during load: load=1, in=16'hBEEF; drop rst_n before the edge and keep it low across the edge -> out=16'h0000 and never shows 16'hBEEF.
